// File: rtl/bist_pkg.sv
// Shared BIST definitions: analyser FSM states, default MISR constants and the
// MISR next-state function used by the response checker.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        CHECK   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    // Computed on a 64-bit carrier so one function serves any width up to 64;
    // callers truncate the result back to their own width.
    function automatic logic [63:0] misr_next(
        input logic [63:0] sig,
        input logic [63:0] poly,
        input logic [63:0] data,
        input int unsigned width
    );
        logic [63:0] mask;
        logic [63:0] nxt;
        logic [5:0]  msb;
        msb = 6'(width - 1);
        if (width >= 64)
            mask = '1;
        else
            mask = (64'd1 << width) - 64'd1;
        nxt = (sig << 1) ^ (sig[msb] ? poly : 64'd0) ^ data;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_response_checker_misr.sv
// Multiple-input signature register: seed load, enable-gated compaction and
// polynomial feedback. Load takes priority over compaction.
module misr
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED  = DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] signature
);

    logic [WIDTH-1:0] sig_next;

    assign sig_next = WIDTH'(misr_next(64'(signature), 64'(POLY), 64'(data), WIDTH));

    always_ff @(posedge clk) begin
        if (reset || load)
            signature <= SEED;
        else if (enable)
            signature <= sig_next;
    end

endmodule

// File: rtl/misr_response_checker.sv
// BIST output-response analyser: compacts CUT words into a MISR, counts them and
// registers a pass/fail verdict at end of run. `MISR_XMASK_EN adds an x_mask port.
module misr_response_checker
    import bist_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] POLY      = DEFAULT_POLY,
    parameter logic [WIDTH-1:0] SEED      = DEFAULT_SEED,
    parameter logic [WIDTH-1:0] GOLDEN    = 16'h0000,
    parameter int unsigned      CNT_W     = 16,
    parameter logic [CNT_W-1:0] EXP_COUNT = 16'd128
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             running,
    input  logic [WIDTH-1:0] data_in,
`ifdef MISR_XMASK_EN
    input  logic [WIDTH-1:0] x_mask,
`endif
    input  logic             bist_end,
    output logic [WIDTH-1:0] signature,
    output logic             done,
    output logic             pass_nfail
);

    localparam logic [CNT_W-1:0] COUNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data_masked;
    logic             compact_en;

`ifdef MISR_XMASK_EN
    assign data_masked = data_in & ~x_mask;
`else
    assign data_masked = data_in;
`endif

    // A start pulse reloads the seed, so the word presented with it is dropped.
    assign compact_en = (state == COMPACT) && running && !start;

    misr #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .enable    (compact_en),
        .data      (data_masked),
        .signature (signature)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            done       <= 1'b0;
            pass_nfail <= 1'b0;
        end else if (start) begin
            state      <= COMPACT;
            count      <= '0;
            done       <= 1'b0;
            pass_nfail <= 1'b0;
        end else begin
            case (state)
                COMPACT: begin
                    if (running && (count != COUNT_MAX))
                        count <= count + 1'b1;
                    if (bist_end)
                        state <= CHECK;
                end
                // The last word (if any) was folded in at the bist_end edge.
                CHECK: begin
                    pass_nfail <= (signature == GOLDEN) && (count == EXP_COUNT);
                    done       <= 1'b1;
                    state      <= DONE;
                end
                IDLE:    ;
                DONE:    ;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_misr_response_checker.sv
// Scoreboard bench for misr_response_checker: randomized runs against a queue-based
// reference model; build with +define+MISR_XMASK_EN to exercise the x_mask port.
module tb_misr_response_checker;

    localparam logic [15:0] POLY      = 16'h002D;
    localparam logic [15:0] SEED      = 16'h0000;
    localparam logic [15:0] GOLDEN    = 16'h0000;
    localparam int          EXP_COUNT = 128;

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } verdict_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        running;
    logic [15:0] data_in;
    logic        bist_end;
    logic [15:0] signature;
    logic        done;
    logic        pass_nfail;
    logic [15:0] cur_mask;
`ifdef MISR_XMASK_EN
    logic [15:0] x_mask;
    assign x_mask = cur_mask;
`endif

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] vecs[$];
    verdict_t    sb[$];
    bit          in_run = 0;
    bit          check_pending = 0;
    bit          exp_done = 0;
    bit          mon_en = 0;
    bit          done_prev = 0;
    logic [15:0] exp_sig = SEED;

    always #5 clk = ~clk;

    misr_response_checker dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .running    (running),
        .data_in    (data_in),
`ifdef MISR_XMASK_EN
        .x_mask     (x_mask),
`endif
        .bist_end   (bist_end),
        .signature  (signature),
        .done       (done),
        .pass_nfail (pass_nfail)
    );

    // Reference: multiply-by-x modulo the polynomial, then add the word.
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
        int unsigned t;
        t = 32'(s) * 2;
        if (t >= 32'h10000)
            t = (t - 32'h10000) ^ 32'(POLY);
        return 16'(t) ^ d;
    endfunction

    function automatic logic [15:0] fold(input logic [15:0] q[$]);
        logic [15:0] s;
        s = SEED;
        foreach (q[i])
            s = misr_step(s, q[i]);
        return s;
    endfunction

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit st, input bit run,
                                  input logic [15:0] d, input bit be);
        verdict_t v;
        reset    = rst;
        start    = st;
        running  = run;
        data_in  = d;
        bist_end = be;
        @(posedge clk);
        if (rst) begin
            vecs.delete();
            in_run = 0;
            check_pending = 0;
            exp_done = 0;
        end else if (st) begin
            vecs.delete();
            in_run = 1;
            check_pending = 0;
            exp_done = 0;
        end else begin
            if (check_pending)
                exp_done = 1;
            check_pending = 0;
            if (in_run) begin
                if (run)
                    vecs.push_back(d & ~cur_mask);
                if (be) begin
                    v.sig  = fold(vecs);
                    v.pass = (v.sig == GOLDEN) && (vecs.size() == EXP_COUNT);
                    sb.push_back(v);
                    in_run = 0;
                    check_pending = 1;
                end
            end
        end
        exp_sig = fold(vecs);
        mon_en = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(0, 0, 0, 16'($urandom), 0);
    endtask

    task automatic zero_words(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(0, 0, 1, 16'h0000, 0);
    endtask

    task automatic random_words(input int n);
        for (int i = 0; i < n; i++)
            apply_stimulus(0, 0, 1, 16'($urandom), 0);
    endtask

    always @(negedge clk) begin
        verdict_t v;
        if (mon_en) begin
            check_output("signature", 32'(signature), 32'(exp_sig));
            check_output("done", 32'(done), 32'(exp_done));
            if (!done)
                check_output("pass_nfail_before_verdict", 32'(pass_nfail), 32'd0);
            if (done && !done_prev) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("[TB] FAIL unexpected_verdict: actual done=1, required no verdict");
                end else begin
                    v = sb.pop_front();
                    check_output("verdict_signature", 32'(signature), 32'(v.sig));
                    check_output("verdict_pass", 32'(pass_nfail), 32'(v.pass));
                end
            end
            done_prev = done;
        end
    end

    initial begin
        logic [15:0] last;
        int          n;
        reset = 1; start = 0; running = 0; data_in = 0; bist_end = 0; cur_mask = 0;

        repeat (3) apply_stimulus(1, 0, 0, 16'h0000, 0);
        check_output("reset_signature", 32'(signature), 32'(SEED));
        check_output("reset_pass", 32'(pass_nfail), 32'd0);
        apply_stimulus(0, 0, 1, 16'hFFFF, 1);
        idle(2);

        // Golden zero run
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        zero_words(128);
        apply_stimulus(0, 0, 0, 16'h0000, 1);
        idle(2);
        check_output("zero_run_pass", 32'(pass_nfail), 32'd1);

        // Single one followed by three zeros
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        apply_stimulus(0, 0, 1, 16'h0001, 0);
        zero_words(3);
        apply_stimulus(0, 0, 0, 16'h0000, 1);
        idle(2);
        check_output("four_vec_signature", 32'(signature), 32'h0008);
        check_output("four_vec_pass", 32'(pass_nfail), 32'd0);

        // Count one short of the expected value
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        zero_words(127);
        apply_stimulus(0, 0, 0, 16'h0000, 1);
        idle(2);
        check_output("short_count_pass", 32'(pass_nfail), 32'd0);

        // Last word compacted in the bist_end cycle; DONE ignores later inputs
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        zero_words(127);
        apply_stimulus(0, 0, 1, 16'h0000, 1);
        idle(2);
        check_output("end_with_word_pass", 32'(pass_nfail), 32'd1);
        apply_stimulus(0, 0, 1, 16'h1234, 1);
        idle(2);

        // Reset in the middle of a run suppresses the verdict
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        random_words(50);
        apply_stimulus(1, 0, 0, 16'h0000, 0);
        apply_stimulus(0, 0, 1, 16'h5555, 1);
        idle(3);
        check_output("reset_mid_run_done", 32'(done), 32'd0);
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        zero_words(128);
        apply_stimulus(0, 0, 0, 16'h0000, 1);
        idle(2);

        // Start colliding with running and with bist_end
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        random_words(10);
        apply_stimulus(0, 1, 1, 16'($urandom), 0);
        random_words(20);
        apply_stimulus(0, 1, 0, 16'h0000, 1);
        zero_words(127);
        apply_stimulus(0, 0, 1, 16'h0000, 1);
        idle(2);

        // Randomized runs; even runs steer the signature onto GOLDEN
        for (int r = 0; r < 8; r++) begin
            apply_stimulus(0, 1, 0, 16'h0000, 0);
            n = (r % 2 == 0) ? EXP_COUNT : 120 + int'($urandom_range(0, 16));
            while (vecs.size() < n - 1) begin
                if ($urandom_range(0, 3) == 0)
                    apply_stimulus(0, 0, 0, 16'($urandom), 0);
                else
                    apply_stimulus(0, 0, 1, 16'($urandom), 0);
            end
            last = (r % 2 == 0) ? misr_step(exp_sig, 16'h0000) : 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                apply_stimulus(0, 0, 1, last, 1);
            end else begin
                apply_stimulus(0, 0, 1, last, 0);
                apply_stimulus(0, 0, 0, 16'h0000, 1);
            end
            idle(2);
        end

`ifdef MISR_XMASK_EN
        cur_mask = 16'hFFFF;
        apply_stimulus(0, 1, 0, 16'h0000, 0);
        random_words(128);
        apply_stimulus(0, 0, 0, 16'h0000, 1);
        idle(2);
        check_output("xmask_pass", 32'(pass_nfail), 32'd1);
        cur_mask = 16'h0000;
`endif

        idle(3);
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
